// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } tx_ctrl_state_e;

    localparam logic [1:0] DB5 = 2'b00;
    localparam logic [1:0] DB6 = 2'b01;
    localparam logic [1:0] DB7 = 2'b10;
    localparam logic [1:0] DB8 = 2'b11;

    // Keeps the low 5..8 bits of a byte for the given data-bit setting.
    function automatic logic [7:0] data_mask(input logic [1:0] db);
        data_mask = 8'hFF >> (2'd3 - db);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered status flags; used by both TX and RX paths.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_d;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot the same-cycle push needs, so a full FIFO still accepts it.
    assign do_pop   = pop && !empty && !flush;
    assign do_push  = push && !flush && (!full || do_pop);
    assign pop_data = mem[rd_ptr];
    assign level    = count;

    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + (AW + 1)'(1);
            2'b01:   count_d = count - (AW + 1)'(1);
            default: count_d = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_d;
            full     <= (count_d == FULL_CNT);
            empty    <= (count_d == '0);
            overflow <= push && full && !do_pop;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// TX controller: buffers bytes from the register file and launches one uart_tx frame per byte.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_data_i,
    input  logic             fifo_flush_i,
    input  logic             tx_enable_i,
    input  logic [1:0]       data_bit_num_i,
    input  logic             parity_en_i,
    input  logic             parity_type_i,
    input  logic             stop_bit_num_i,
    input  logic             cts_n,
    input  logic             tx_done_i,
    output logic             start_tx_o,
    output logic [31:0]      tx_data_o,
    output logic [1:0]       data_bit_num_o,
    output logic             parity_en_o,
    output logic             parity_type_o,
    output logic             stop_bit_num_o,
    output logic             fifo_empty_o,
    output logic             fifo_full_o,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic [1:0]       dbg_state
);

    tx_ctrl_state_e state_q;
    tx_ctrl_state_e state_d;
    logic           done_q;
    logic           done_rise;
    logic           launch;
    logic           pop;
    logic [7:0]     fifo_head;

    uart_sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en_i),
        .push_data(wr_data_i),
        .pop      (pop),
        .pop_data (fifo_head),
        .flush    (fifo_flush_i),
        .full     (fifo_full_o),
        .empty    (fifo_empty_o),
        .level    (fifo_level_o),
        .overflow (overflow_o)
    );

    // Handshake: start_tx_o is a one-cycle launch strobe with tx_data_o and the
    // config outputs already stable; the frame is finished on the first cycle
    // tx_done_i is seen high after being low, so pulse and level done both work.
    assign done_rise = tx_done_i && !done_q;
    assign launch    = !fifo_empty_o && tx_enable_i && !cts_n && !fifo_flush_i;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = LOAD;
                    pop     = 1'b1;
                end
            end
            LOAD:    state_d = WAIT;
            WAIT:    if (done_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            done_q         <= 1'b0;
            start_tx_o     <= 1'b0;
            busy_o         <= 1'b0;
            tx_data_o      <= '0;
            data_bit_num_o <= DB8;
            parity_en_o    <= 1'b0;
            parity_type_o  <= 1'b0;
            stop_bit_num_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= tx_done_i;
            start_tx_o <= (state_d == LOAD);
            busy_o     <= (state_d != IDLE);
            // Frame data and config are frozen here until the next launch.
            if (pop) begin
                tx_data_o      <= {24'b0, fifo_head & data_mask(data_bit_num_i)};
                data_bit_num_o <= data_bit_num_i;
                parity_en_o    <= parity_en_i;
                parity_type_o  <= parity_type_i;
                stop_bit_num_o <= stop_bit_num_i;
            end
        end
    end

endmodule
